// File: rtl/traffic_pkg.sv
// Shared state codes and lamp encodings for the highway/farm traffic light.
// Lamp vectors are ordered {HG, HY, HR, FG, FY, FR}.
package traffic_pkg;

  typedef enum logic [2:0] {
    HGRN  = 3'd0,
    HYEL  = 3'd1,
    AR1   = 3'd2,
    FGRN  = 3'd3,
    FYEL  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } st_e;

  localparam logic [5:0] LMP_HGRN   = 6'b100_001;
  localparam logic [5:0] LMP_HYEL   = 6'b010_001;
  localparam logic [5:0] LMP_AR     = 6'b001_001;
  localparam logic [5:0] LMP_FGRN   = 6'b001_100;
  localparam logic [5:0] LMP_FYEL   = 6'b001_010;
  localparam logic [5:0] LMP_FL_ON  = 6'b010_001;
  localparam logic [5:0] LMP_FL_OFF = 6'b000_001;

  function automatic logic [5:0] lamp_enc(input st_e st, input logic fph);
    logic [5:0] l;
    case (st)
      HGRN:    l = LMP_HGRN;
      HYEL:    l = LMP_HYEL;
      FGRN:    l = LMP_FGRN;
      FYEL:    l = LMP_FYEL;
      FLASH:   l = fph ? LMP_FL_ON : LMP_FL_OFF;
      default: l = LMP_AR;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_load)                   r_cnt <= i_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Highway/farm-road intersection controller with sensor-extended highway green
// and a night flashing mode entered only through an all-red phase.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int HG_MIN = 8,
  parameter int Y_CYC  = 2,
  parameter int AR_CYC = 1,
  parameter int FG_CYC = 5,
  parameter int FL_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             farm_req,
  input  logic             flash,
  output logic             HG,
  output logic             HY,
  output logic             HR,
  output logic             FG,
  output logic             FY,
  output logic             FR,
  output logic [2:0]       ST,
  output logic [CNT_W-1:0] tmr
);

  localparam logic [CNT_W-1:0] LD_HG = CNT_W'(HG_MIN - 1);
  localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] LD_AR = CNT_W'(AR_CYC - 1);
  localparam logic [CNT_W-1:0] LD_FG = CNT_W'(FG_CYC - 1);
  localparam logic [CNT_W-1:0] LD_FL = CNT_W'(FL_CYC - 1);

  st_e              r_st, w_nxt;
  logic             r_fph, w_fph_nxt;
  logic [5:0]       r_lmp;
  logic             w_load, w_zero;
  logic [CNT_W-1:0] w_ldval, w_cnt;

  phase_timer #(.CNT_W(CNT_W)) u_tmr (
    .clk    (clk),
    .i_load (reset | (enable & w_load)),
    .i_val  (reset ? LD_HG : w_ldval),
    .i_dec  (enable & ~reset),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );

  always_comb begin
    w_nxt     = r_st;
    w_fph_nxt = r_fph;
    w_load    = 1'b0;
    w_ldval   = '0;
    case (r_st)
      HGRN: if (w_zero && farm_req) begin
        w_nxt = HYEL; w_load = 1'b1; w_ldval = LD_Y;
      end
      HYEL: if (w_zero) begin
        w_nxt = AR1; w_load = 1'b1; w_ldval = LD_AR;
      end
      AR1: if (w_zero) begin
        w_load = 1'b1;
        if (flash) begin w_nxt = FLASH; w_ldval = LD_FL; w_fph_nxt = 1'b1; end
        else       begin w_nxt = FGRN;  w_ldval = LD_FG; end
      end
      // An empty farm road cuts the green short after its first cycle.
      FGRN: if (w_zero || !farm_req) begin
        w_nxt = FYEL; w_load = 1'b1; w_ldval = LD_Y;
      end
      FYEL: if (w_zero) begin
        w_nxt = AR2; w_load = 1'b1; w_ldval = LD_AR;
      end
      AR2: if (w_zero) begin
        w_load = 1'b1;
        if (flash) begin w_nxt = FLASH; w_ldval = LD_FL; w_fph_nxt = 1'b1; end
        else       begin w_nxt = HGRN;  w_ldval = LD_HG; end
      end
      FLASH: if (w_zero) begin
        w_load = 1'b1;
        if (flash) begin w_ldval = LD_FL; w_fph_nxt = ~r_fph; end
        else       begin w_nxt = AR2; w_ldval = LD_AR; end
      end
      default: begin
        w_nxt = AR2; w_load = 1'b1; w_ldval = LD_AR;
      end
    endcase
  end

  // Lamps are registered from the next state so they always match ST.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st  <= HGRN;
      r_fph <= 1'b1;
      r_lmp <= LMP_HGRN;
    end else if (enable) begin
      r_st  <= w_nxt;
      r_fph <= w_fph_nxt;
      r_lmp <= lamp_enc(w_nxt, w_fph_nxt);
    end
  end

  assign {HG, HY, HR, FG, FY, FR} = r_lmp;
  assign ST  = r_st;
  assign tmr = w_cnt;

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning phase-timer width in bits.
REQ-002 SHALL have parameter HG_MIN, default 8, meaning minimum highway-green cycles.
REQ-003 SHALL have parameter Y_CYC, default 2, meaning yellow cycles for either road.
REQ-004 SHALL have parameter AR_CYC, default 1, meaning all-red cycles between greens.
REQ-005 SHALL have parameter FG_CYC, default 5, meaning farm-green cycles.
REQ-006 SHALL have parameter FL_CYC, default 3, meaning flash half-period in cycles.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-009 SHALL have port enable, input, 1 bit, meaning advance timer/state when 1 and freeze everything when 0.
REQ-010 SHALL have port farm_req, input, 1 bit, meaning farm-road vehicle sensor, level-sensitive.
REQ-011 SHALL have port flash, input, 1 bit, meaning night flashing-mode request.
REQ-012 SHALL have ports HG, HY, HR, input-free outputs, 1 bit each, meaning highway green/yellow/red lamps.
REQ-013 SHALL have ports FG, FY, FR, outputs, 1 bit each, meaning farm green/yellow/red lamps.
REQ-014 SHALL have port ST, output, 3 bits, meaning current state code.
REQ-015 SHALL have port tmr, output, CNT_W bits, meaning remaining cycles in the current phase.

Function
REQ-016 SHALL implement states with ST codes: HGRN=0, HYEL=1, AR1=2, FGRN=3, FYEL=4, AR2=5, FLASH=6; code 7 unused and returns to AR2 on the next enabled edge.
REQ-017 SHALL load tmr with (duration-1) on entry to each timed state and decrement by 1 each enabled cycle; a phase ends on the enabled edge where tmr==0.
REQ-018 SHALL use durations: HYEL/FYEL=Y_CYC, AR1/AR2=AR_CYC, FGRN=FG_CYC, HGRN=HG_MIN (floor), FLASH=FL_CYC per half-period.
REQ-019 SHALL hold HGRN with tmr at 0 once the floor expires until farm_req==1, then go to HYEL on that same edge.
REQ-020 SHALL sequence HGRN->HYEL->AR1->FGRN->FYEL->AR2->HGRN.
REQ-021 SHALL end FGRN early by going to FYEL on any enabled edge where farm_req==0 and at least 1 FGRN cycle has elapsed.
REQ-022 SHALL enter FLASH only from AR1 or AR2 at phase end when flash==1; never directly from a green or yellow state.
REQ-023 SHALL exit FLASH to AR2 at the end of a half-period when flash==0, giving AR_CYC all-red before HGRN.
REQ-024 SHALL drive lamps by state, with exactly one highway lamp and one farm lamp lit at all times: HGRN HG+FR; HYEL HY+FR; AR1/AR2 HR+FR; FGRN HR+FG; FYEL HR+FY.
REQ-025 SHALL drive FLASH as FR=1 constantly, HR=HG=0, and HY alternating 1 then 0 for FL_CYC cycles each, starting at 1; this is the only state where the highway lamp set may be all dark.
REQ-026 SHALL register all outputs, derived from the registered state/timer, so that no output is combinationally dependent on an input.
REQ-027 SHALL leave state, tmr, and the flash phase unchanged when enable==0, regardless of farm_req or flash.
REQ-028 SHALL require every duration parameter to be >=1 and <2^CNT_W; a duration of 1 means tmr is loaded with 0 and the state lasts one enabled cycle.

Reset
REQ-029 SHALL, when reset==1 at a clock edge, override enable and load ST=HGRN and tmr=HG_MIN-1, with HG=1, FR=1, and all other lamps 0.
REQ-030 SHALL take reset from any state, including mid-FLASH or mid-FYEL, with identical result; the flash phase restarts at 1.

Structure
REQ-031 SHALL place state codes and the lamp-encoding constants in the shared package traffic_pkg.
REQ-032 SHALL use the sub-module phase_timer (loadable down-counter, CNT_W wide, with load, dec, and zero flag); the FSM stays in the top level.

Verification
REQ-033 SHALL cover: reset=1 for 2 cycles then enable=1, farm_req=0 -> HG=1/FR=1 held indefinitely, tmr stops at 0 after 8 cycles.
REQ-034 SHALL cover: farm_req=1 from cycle 0 -> HGRN 8, HYEL 2, AR1 1, FGRN 5, FYEL 2, AR2 1 cycles, ST sequence 0,1,2,3,4,5,0.
REQ-035 SHALL cover: farm_req dropped on the 2nd FGRN cycle -> FYEL entered on the next edge, FGRN lasting 2 cycles.
REQ-036 SHALL cover: flash=1 asserted during HGRN -> the light completes HYEL and AR1, enters ST=6, and HY toggles every 3 cycles; flash=0 -> AR2 for 1 cycle, then HGRN.
REQ-037 SHALL cover: enable=0 for 4 cycles mid-HYEL -> ST and tmr frozen, and the phase resumes with the remaining count.
REQ-038 SHALL cover: reset pulsed mid-FLASH -> ST=0 and tmr=7 on the next edge; a lamp checker asserts exactly-one-lamp-per-road throughout, except highway in FLASH.
